// File: rtl/test_status_responder_if.sv
// Write-request and console-byte bus between the core's data-write path and
// the end-of-test responder.
interface test_status_responder_if #(
  parameter int AW = 16
) ();
  logic          ReqValid;
  logic          ReqReady;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic          CharValid;
  logic          CharReady;
  logic [7:0]    CharData;

  modport master (
    output ReqValid, Address, WriteData, CharReady,
    input  ReqReady, CharValid, CharData
  );

  modport slave (
    input  ReqValid, Address, WriteData, CharReady,
    output ReqReady, CharValid, CharData
  );
endinterface

// File: rtl/test_status_responder.sv
// End-of-test responder: latches a pass/fail/timeout verdict, accumulates a
// signature and buffers one console byte. Define TEST_STATUS_CYCLE_COUNT_EN
// to build the saturating RUN-cycle counter on CycleCount.
module test_status_responder #(
  parameter int            AW             = 16,
  parameter logic [AW-1:0] BASE           = 16'hFF00,
  parameter int            TIMEOUT_CYCLES = 5000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  test_status_responder_if.slave  bus,
  output logic                    Done,
  output logic                    Pass,
  output logic                    TimedOut,
  output logic [30:0]             FailCode,
  output logic [31:0]             Signature,
  output logic [31:0]             CycleCount
);

  typedef enum logic [1:0] {ST_RUN, ST_PASSED, ST_FAILED, ST_TIMEOUT} state_e;

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e        r_state, w_state_next;
  logic [30:0]   r_fail_code;
  logic [31:0]   r_signature;
  logic [31:0]   r_wd_cnt;
  logic          r_char_valid;
  logic [7:0]    r_char_data;

  logic [AW-1:0] w_offset;
  logic          w_is_status, w_is_sig, w_is_console;
  logic          w_req_ready, w_fire, w_wd_expire;

  assign w_offset     = bus.Address - BASE;
  assign w_is_status  = (w_offset == AW'(0));
  assign w_is_sig     = (w_offset == AW'(4));
  assign w_is_console = (w_offset == AW'(8));
  assign w_wd_expire  = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_fire       = 1'b0;
    if (r_state == ST_RUN) begin
      // A draining byte frees the buffer this cycle, so a new byte may enter.
      w_req_ready = !(w_is_console && r_char_valid && !bus.CharReady);
      w_fire      = bus.ReqValid && w_req_ready;
      if (w_fire && w_is_status && bus.WriteData == 32'd1)
        w_state_next = ST_PASSED;
      else if (w_fire && w_is_status && bus.WriteData != 32'd0)
        w_state_next = ST_FAILED;
      else if (w_wd_expire)
        w_state_next = ST_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= ST_RUN;
      r_fail_code  <= '0;
      r_signature  <= '0;
      r_wd_cnt     <= '0;
      r_char_valid <= 1'b0;
      r_char_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_RUN)
        r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_fire && w_is_status && bus.WriteData > 32'd1)
        r_fail_code <= bus.WriteData[31:1];
      if (w_fire && w_is_sig)
        r_signature <= {r_signature[30:0], r_signature[31]} ^ bus.WriteData;
      if (w_fire && w_is_console) begin
        r_char_data  <= bus.WriteData[7:0];
        r_char_valid <= 1'b1;
      end else if (bus.CharReady) begin
        r_char_valid <= 1'b0;
      end
    end
  end

`ifdef TEST_STATUS_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge Clock) begin
    if (Reset)
      r_cycle_count <= '0;
    else if (r_state == ST_RUN && r_cycle_count != '1)
      r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign CycleCount = r_cycle_count;
`else
  assign CycleCount = '0;
`endif

  assign bus.ReqReady  = w_req_ready;
  assign bus.CharValid = r_char_valid;
  assign bus.CharData  = r_char_data;
  assign Done          = (r_state != ST_RUN);
  assign Pass          = (r_state == ST_PASSED);
  assign TimedOut      = (r_state == ST_TIMEOUT);
  assign FailCode      = r_fail_code;
  assign Signature     = r_signature;

endmodule

// File: tb/tb_test_status_responder.sv
// Directed bench for test_status_responder: verdicts, signature, console
// backpressure, watchdog timeout and mid-run reset.
module tb_test_status_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Done, Pass, TimedOut;
  logic [30:0] FailCode;
  logic [31:0] Signature, CycleCount;

  int checks = 0;
  int errors = 0;

  test_status_responder_if #(.AW(16)) bus ();

  test_status_responder #(
    .AW(16), .BASE(16'hFF00), .TIMEOUT_CYCLES(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .Done(Done), .Pass(Pass), .TimedOut(TimedOut), .FailCode(FailCode),
    .Signature(Signature), .CycleCount(CycleCount)
  );

  always #5 Clock = ~Clock;

`ifdef TEST_STATUS_CYCLE_COUNT_EN
  localparam logic [31:0] EXP_CYCLES = 32'd20;
`else
  localparam logic [31:0] EXP_CYCLES = 32'd0;
`endif

  // Leaves the bench just after the negedge that follows reset release.
  task automatic do_reset();
    @(negedge Clock);
    Reset         = 1'b1;
    bus.ReqValid  = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.CharReady = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Drives one request for one edge; rdy is ReqReady just before that edge.
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                           output logic rdy);
    bus.ReqValid  = 1'b1;
    bus.Address   = a;
    bus.WriteData = d;
    #1 rdy = bus.ReqReady;
    @(posedge Clock);
    @(negedge Clock);
    bus.ReqValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Done, Pass, TimedOut, FailCode, Signature, CycleCount, bus.CharValid, bus.CharData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got done=%b pass=%b to=%b fc=%h sig=%h cc=%h cv=%b cd=%h expected all 0",
               Done, Pass, TimedOut, FailCode, Signature, CycleCount, bus.CharValid, bus.CharData);
    end
  endtask

  task automatic test_pass();
    logic rdy;
    do_reset();
    bus_write(16'hFF00, 32'h0, rdy);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL status_noop done got %b expected 0", Done); end
    bus_write(16'hFF00, 32'h1, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL pass_ready got %b expected 1", rdy); end
    checks++;
    if ({Done, Pass, TimedOut, FailCode} !== {3'b110, 31'd0}) begin
      errors++; $display("FAIL pass_verdict got done=%b pass=%b to=%b fc=%h expected 1 1 0 0", Done, Pass, TimedOut, FailCode);
    end
    bus_write(16'hFF04, 32'h1234, rdy);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL terminal_ready got %b expected 0", rdy); end
    checks++;
    if (Signature !== 32'h0) begin errors++; $display("FAIL terminal_sig got %h expected 0", Signature); end
  endtask

  task automatic test_fail();
    logic rdy;
    do_reset();
    bus_write(16'hFF0C, 32'h1, rdy);
    checks++;
    if ({rdy, Done} !== 2'b10) begin errors++; $display("FAIL unmapped got rdy=%b done=%b expected 1 0", rdy, Done); end
    bus_write(16'hFF00, 32'h0000_002B, rdy);
    checks++;
    if ({Done, Pass, TimedOut, FailCode} !== {3'b100, 31'h15}) begin
      errors++; $display("FAIL fail_verdict got done=%b pass=%b to=%b fc=%h expected 1 0 0 15", Done, Pass, TimedOut, FailCode);
    end
  endtask

  task automatic test_signature();
    logic rdy;
    do_reset();
    bus_write(16'hFF04, 32'h8000_0001, rdy);
    checks++;
    if (Signature !== 32'h8000_0001) begin errors++; $display("FAIL sig_first got %h expected 80000001", Signature); end
    bus_write(16'hFF04, 32'h0000_0003, rdy);
    checks++;
    if (Signature !== 32'h0) begin errors++; $display("FAIL sig_rotate got %h expected 00000000", Signature); end
  endtask

  task automatic test_console();
    logic rdy;
    do_reset();
    bus_write(16'hFF08, 32'h41, rdy);
    checks++;
    if ({bus.CharValid, bus.CharData} !== {1'b1, 8'h41}) begin
      errors++; $display("FAIL console_first got cv=%b cd=%h expected 1 41", bus.CharValid, bus.CharData);
    end
    bus.ReqValid = 1'b1; bus.Address = 16'hFF08; bus.WriteData = 32'h42;
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({bus.ReqReady, bus.CharData} !== {1'b0, 8'h41}) begin
      errors++; $display("FAIL console_backpressure got rdy=%b cd=%h expected 0 41", bus.ReqReady, bus.CharData);
    end
    bus.CharReady = 1'b1;
    #1;
    checks++;
    if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL console_ready_rise got %b expected 1", bus.ReqReady); end
    @(posedge Clock);
    @(negedge Clock);
    bus.ReqValid  = 1'b0;
    bus.CharReady = 1'b0;
    checks++;
    if ({bus.CharValid, bus.CharData} !== {1'b1, 8'h42}) begin
      errors++; $display("FAIL console_swap got cv=%b cd=%h expected 1 42", bus.CharValid, bus.CharData);
    end
    bus.CharReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.CharReady = 1'b0;
    checks++;
    if (bus.CharValid !== 1'b0) begin errors++; $display("FAIL console_drain got %b expected 0", bus.CharValid); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (19) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL timeout_early done got %b expected 0", Done); end
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({Done, Pass, TimedOut} !== 3'b101) begin
      errors++; $display("FAIL timeout_verdict got done=%b pass=%b to=%b expected 1 0 1", Done, Pass, TimedOut);
    end
    checks++;
    if (CycleCount !== EXP_CYCLES) begin errors++; $display("FAIL timeout_cycles got %0d expected %0d", CycleCount, EXP_CYCLES); end
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({TimedOut, CycleCount} !== {1'b1, EXP_CYCLES}) begin
      errors++; $display("FAIL timeout_hold got to=%b cc=%0d expected 1 %0d", TimedOut, CycleCount, EXP_CYCLES);
    end
  endtask

  task automatic test_timeout_race();
    logic rdy;
    do_reset();
    repeat (19) @(posedge Clock);
    @(negedge Clock);
    bus_write(16'hFF00, 32'h1, rdy);
    checks++;
    if ({rdy, Done, Pass, TimedOut} !== 4'b1110) begin
      errors++; $display("FAIL timeout_race got rdy=%b done=%b pass=%b to=%b expected 1 1 1 0", rdy, Done, Pass, TimedOut);
    end
  endtask

  task automatic test_mid_reset();
    logic rdy;
    do_reset();
    bus_write(16'hFF04, 32'h1234_5678, rdy);
    bus_write(16'hFF08, 32'h55, rdy);
    bus_write(16'hFF00, 32'h2, rdy);
    checks++;
    if ({Signature, bus.CharValid, Done} !== {32'h1234_5678, 2'b11}) begin
      errors++; $display("FAIL midreset_setup got sig=%h cv=%b done=%b expected 12345678 1 1", Signature, bus.CharValid, Done);
    end
    Reset = 1'b1;
    bus.Address = 16'hFF08;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++;
    if ({Done, Pass, TimedOut, FailCode, Signature, CycleCount, bus.CharValid, bus.CharData} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got done=%b fc=%h sig=%h cc=%h cv=%b cd=%h expected all 0",
               Done, FailCode, Signature, CycleCount, bus.CharValid, bus.CharData);
    end
    checks++;
    if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b expected 1", bus.ReqReady); end
  endtask

  initial begin
    bus.ReqValid  = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.CharReady = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_signature();
    test_console();
    test_timeout();
    test_timeout_race();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
